// File: rtl/serial_sub10.sv
// ----------------------------------------------------------------------------
// serial_sub10
//
// Bit-serial unsigned subtractor computing d = (a - b - bin) mod 2^WIDTH and
// bout = (a < b + bin). One bit is processed per clock, LSB first, so a
// request takes WIDTH cycles from accept to result. Requests and results use
// valid/ready handshakes. After a result is consumed, the block spends one
// edge returning to IDLE before it can accept the next request.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a, b, bin carry a request
//   in_ready   out  block is idle and can accept a request
//   a          in   minuend (WIDTH bits, unsigned)
//   b          in   subtrahend (WIDTH bits, unsigned)
//   bin        in   borrow-in
//   out_valid  out  d and bout hold a completed result
//   out_ready  in   consumer accepts the result
//   d          out  difference (WIDTH bits)
//   bout       out  borrow-out
// ----------------------------------------------------------------------------
module serial_sub10 #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    // a_sh doubles as the result accumulator: each SHIFT edge consumes its
    // LSB and inserts the new difference bit at the MSB, so after WIDTH
    // shifts it holds the complete difference.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic             a_bit;
    logic             b_bit;
    logic             diff_bit;
    logic             borrow_nx;
    logic             last_bit;
    logic             accept;

    // ------------------------------------------------------------------
    // Single-bit full subtractor on the current LSBs
    // ------------------------------------------------------------------
    assign a_bit     = a_sh[0];
    assign b_bit     = b_sh[0];
    assign diff_bit  = a_bit ^ b_bit ^ borrow;
    assign borrow_nx = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    assign accept    = (state == IDLE) && in_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked processes use non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of the order
    // in which the processes are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned,
    // so no latch is inferred when a case arm leaves state_nx untouched.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = SHIFT;
            SHIFT:   if (last_bit)  state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from state only)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ------------------------------------------------------------------
    // Datapath: operand shift registers, borrow flop and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= {diff_bit, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            borrow <= borrow_nx;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result registers: written only on the SHIFT-to-DONE edge so the last
    // result stays visible through IDLE and the next SHIFT phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            bout <= 1'b0;
        end else if ((state == SHIFT) && last_bit) begin
            d    <= {diff_bit, a_sh[WIDTH-1:1]};
            bout <= borrow_nx;
        end
    end

endmodule
